// File: rtl/set_associative_cache_pkg.sv
// Shared constants and types for the 2-way read-only instruction cache.
package set_associative_cache_pkg;

    localparam logic [12:0] READ_TAG = 13'h1100;

    localparam logic [1:0] FLAG_IDLE  = 2'd0;
    localparam logic [1:0] FLAG_READ  = 2'd1;
    localparam logic [1:0] FLAG_INVAL = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        REQ,
        RESP,
        FILL
    } state_e;

endpackage

// File: rtl/cache_refill_fsm.sv
// Miss handling: arbitration, single line-read request, beat collection into a line buffer.
module cache_refill_fsm
    import set_associative_cache_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int BEAT_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       line_addr_i,
    input  logic                    victim_i,
    input  logic                    grant_i,
    input  logic                    reqack_i,
    input  logic                    respcyc_i,
    input  logic [BEAT_W-1:0]       resp_i,
    output state_e                  state_o,
    output logic [ADDR_W-1:0]       line_addr_o,
    output logic                    victim_o,
    output logic [BEATS*BEAT_W-1:0] line_o,
    output logic                    arb_reqcyc_o,
    output logic                    bus_reqcyc_o,
    output logic [ADDR_W-1:0]       bus_req_o,
    output logic [TAG_W-1:0]        bus_reqtag_o,
    output logic                    bus_respack_o,
    output logic                    bus_busy_o
);

    localparam int CNT_W = $clog2(BEATS);

    state_e                        state_q;
    logic [ADDR_W-1:0]             line_q;
    logic                          victim_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [BEATS-1:0][BEAT_W-1:0]  buf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            line_q   <= '0;
            victim_q <= 1'b0;
            cnt_q    <= '0;
            buf_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    line_q   <= line_addr_i;
                    victim_q <= victim_i;
                    cnt_q    <= '0;
                    state_q  <= ARB;
                end
                ARB:  if (grant_i)  state_q <= REQ;
                REQ:  if (reqack_i) state_q <= RESP;
                RESP: if (respcyc_i) begin
                    buf_q[cnt_q] <= resp_i;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BEATS-1)) state_q <= FILL;
                end
                FILL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o       = state_q;
    assign line_addr_o   = line_q;
    assign victim_o      = victim_q;
    assign line_o        = buf_q;
    assign arb_reqcyc_o  = (state_q == ARB);
    assign bus_reqcyc_o  = (state_q == REQ);
    assign bus_req_o     = (state_q == REQ) ? line_q : '0;
    assign bus_reqtag_o  = (state_q == REQ) ? TAG_W'(READ_TAG) : '0;
    // Ack is combinational so each beat is acknowledged in the cycle it is presented.
    assign bus_respack_o = (state_q == RESP) && respcyc_i;
    assign bus_busy_o    = (state_q == REQ) || (state_q == RESP) || (state_q == FILL);

endmodule

// File: rtl/set_associative_cache.sv
// 2-way set-associative read-only instruction cache: tag/data arrays, lookup and LRU.
module set_associative_cache
    import set_associative_cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 64,
    parameter int NUM_WAYS       = 2,
    parameter int LINE_BYTES     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDRESS_WIDTH-1:0]  addr,
    input  logic [1:0]                rd_wr_evict_flag,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      data_available,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      addr_data_abtr_grant,
    output logic                      addr_data_abtr_reqcyc,
    input  logic                      store_data_abtr_grant,
    output logic                      store_data_abtr_reqcyc,
    output logic                      store_data_bus_busy,
    output logic                      addr_data_bus_busy
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDRESS_WIDTH - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / BUS_DATA_WIDTH;

    logic [1:0]        valid_q [NUM_SETS];
    logic              lru_q   [NUM_SETS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag;
    logic [OFF_W-3:0]         wsel;
    logic [1:0]               way_match;
    logic                     hit;
    logic                     hit_way;
    logic [LINE_W-1:0]        hit_line;
    logic                     start;
    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] fill_addr;
    logic                     fill_way;
    logic [LINE_W-1:0]        fill_line;
    logic [IDX_W-1:0]         fill_idx;
    logic [TAG_W-1:0]         fill_tag;
    logic [ADDRESS_WIDTH-1:0] fsm_bus_req;

    assign idx  = addr[OFF_W +: IDX_W];
    assign tag  = addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign wsel = addr[OFF_W-1:2];

    always_comb begin
        way_match = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            way_match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end

    assign hit            = (rd_wr_evict_flag == FLAG_READ) && (|way_match);
    assign hit_way        = way_match[1];
    assign hit_line       = data_q[idx][hit_way];
    assign read_data      = hit ? hit_line[{wsel, 5'b0} +: DATA_WIDTH] : '0;
    assign data_available = hit;
    assign start          = (state == IDLE) && (rd_wr_evict_flag == FLAG_READ) && !(|way_match);

    assign fill_idx = fill_addr[OFF_W +: IDX_W];
    assign fill_tag = fill_addr[ADDRESS_WIDTH-1 -: TAG_W];

    cache_refill_fsm #(
        .ADDR_W (ADDRESS_WIDTH),
        .BEAT_W (BUS_DATA_WIDTH),
        .TAG_W  (BUS_TAG_WIDTH),
        .BEATS  (BEATS)
    ) u_refill (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .line_addr_i   ({addr[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}}),
        .victim_i      (lru_q[idx]),
        .grant_i       (addr_data_abtr_grant),
        .reqack_i      (bus_reqack),
        .respcyc_i     (bus_respcyc),
        .resp_i        (bus_resp),
        .state_o       (state),
        .line_addr_o   (fill_addr),
        .victim_o      (fill_way),
        .line_o        (fill_line),
        .arb_reqcyc_o  (addr_data_abtr_reqcyc),
        .bus_reqcyc_o  (bus_reqcyc),
        .bus_req_o     (fsm_bus_req),
        .bus_reqtag_o  (bus_reqtag),
        .bus_respack_o (bus_respack),
        .bus_busy_o    (addr_data_bus_busy)
    );

    assign bus_req                = BUS_DATA_WIDTH'(fsm_bus_req);
    assign store_data_abtr_reqcyc = 1'b0;
    assign store_data_bus_busy    = 1'b0;

    // Fill is last so it wins over a same-cycle hit update in the filled set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                lru_q[s]   <= 1'b0;
            end
        end else begin
            if (hit)
                lru_q[idx] <= ~hit_way;
            if ((state == IDLE) && (rd_wr_evict_flag == FLAG_INVAL))
                valid_q[idx] <= valid_q[idx] & ~way_match;
            if (state == FILL) begin
                valid_q[fill_idx][fill_way] <= 1'b1;
                lru_q[fill_idx]             <= ~fill_way;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tag_q[fill_idx][fill_way]  <= fill_tag;
            data_q[fill_idx][fill_way] <= fill_line;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{store_data_abtr_grant, bus_resptag, addr[1:0], fill_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_set_associative_cache.sv
// Self-checking bench for set_associative_cache: refill handshakes, hits, LRU, invalidate, reset.
module tb_set_associative_cache;
    import set_associative_cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr;
    logic [1:0]  rd_wr_evict_flag;
    logic [31:0] read_data;
    logic        data_available;
    logic        bus_reqcyc, bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc, bus_reqack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        addr_data_abtr_grant, addr_data_abtr_reqcyc;
    logic        store_data_abtr_grant, store_data_abtr_reqcyc;
    logic        store_data_bus_busy, addr_data_bus_busy;

    set_associative_cache dut (
        .clk(clk), .reset(reset), .addr(addr), .rd_wr_evict_flag(rd_wr_evict_flag),
        .read_data(read_data), .data_available(data_available),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .addr_data_abtr_grant(addr_data_abtr_grant), .addr_data_abtr_reqcyc(addr_data_abtr_reqcyc),
        .store_data_abtr_grant(store_data_abtr_grant), .store_data_abtr_reqcyc(store_data_abtr_reqcyc),
        .store_data_bus_busy(store_data_bus_busy), .addr_data_bus_busy(addr_data_bus_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [1:0]  f;
        logic        av;
        logic [31:0] d;
    } vec_t;

    typedef struct {
        logic        av;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   checks   = 0;
    int   failures = 0;

    // Memory model: every word's content is derived from its own byte address.
    function automatic logic [31:0] mw(input logic [63:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic logic [63:0] beat(input logic [63:0] line, input int k);
        return {mw(line + 64'(8*k + 4)), mw(line + 64'(8*k))};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_av"},      64'(data_available), 64'd0);
        chk({nm, "_rdata"},   64'(read_data), 64'd0);
        chk({nm, "_reqcyc"},  64'(bus_reqcyc), 64'd0);
        chk({nm, "_respack"}, 64'(bus_respack), 64'd0);
        chk({nm, "_req"},     bus_req, 64'd0);
        chk({nm, "_reqtag"},  64'(bus_reqtag), 64'd0);
        chk({nm, "_arb"},     64'(addr_data_abtr_reqcyc), 64'd0);
        chk({nm, "_busy"},    64'(addr_data_bus_busy), 64'd0);
        chk({nm, "_st_req"},  64'(store_data_abtr_reqcyc), 64'd0);
        chk({nm, "_st_busy"}, 64'(store_data_bus_busy), 64'd0);
    endtask

    // One IDLE-state lookup: expectation queued at drive time, compared when sampled.
    task automatic do_vec(input logic [63:0] a, input logic [1:0] f, input logic av, input logic [31:0] d);
        exp_t e;
        addr             = a;
        rd_wr_evict_flag = f;
        sb.push_back('{av: av, d: d});
        @(negedge clk);
        e = sb.pop_front();
        chk("vec_av", 64'(data_available), 64'(e.av));
        chk("vec_rdata", 64'(read_data), 64'(e.d));
        chk("vec_no_arb", 64'(addr_data_abtr_reqcyc), 64'd0);
        step();
    endtask

    task automatic refill(input logic [63:0] line, input int gd, input int ad, input int gap,
                          input bit drop, input bit side, input logic [63:0] side_a,
                          input logic [31:0] side_d, input int abort);
        int acks = 0;
        addr = line; rd_wr_evict_flag = FLAG_READ;
        addr_data_abtr_grant = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
        @(negedge clk);
        chk("miss_av", 64'(data_available), 64'd0);
        chk("miss_arb", 64'(addr_data_abtr_reqcyc), 64'd0);
        step();
        if (drop) rd_wr_evict_flag = FLAG_IDLE;
        for (int i = 0; i <= gd; i++) begin
            addr_data_abtr_grant = (i == gd);
            @(negedge clk);
            chk("arb_req", 64'(addr_data_abtr_reqcyc), 64'd1);
            chk("arb_no_bus", 64'(bus_reqcyc), 64'd0);
            step();
        end
        addr_data_abtr_grant = 1'b0;
        for (int i = 0; i <= ad; i++) begin
            bus_reqack = (i == ad);
            @(negedge clk);
            chk("req_cyc", 64'(bus_reqcyc), 64'd1);
            chk("req_addr", bus_req, line);
            chk("req_tag", 64'(bus_reqtag), 64'h1100);
            chk("req_busy", 64'(addr_data_bus_busy), 64'd1);
            step();
        end
        bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus_respcyc = 1'b0;
                @(negedge clk);
                chk("gap_ack", 64'(bus_respack), 64'd0);
                chk("resp_busy", 64'(addr_data_bus_busy), 64'd1);
                step();
            end
            bus_respcyc = 1'b1;
            bus_resp    = beat(line, k);
            if (side && k == 3) begin
                addr = side_a;
                rd_wr_evict_flag = FLAG_READ;
            end
            @(negedge clk);
            chk("beat_ack", 64'(bus_respack), 64'd1);
            if (bus_respack === 1'b1) acks++;
            if (side && k == 3) begin
                chk("side_av", 64'(data_available), 64'd1);
                chk("side_rdata", 64'(read_data), 64'(side_d));
            end
            if (abort != 0 && k == abort - 1) begin
                reset = 1'b0;
                addr  = 64'h2000;
                rd_wr_evict_flag = FLAG_READ;
                #1;
                chk_all_zero("rst_mid");
                step();
                chk_all_zero("rst_hold");
                reset = 1'b1;
                bus_respcyc = 1'b0;
                return;
            end
            step();
            addr = line;
        end
        bus_respcyc = 1'b0;
        rd_wr_evict_flag = FLAG_READ;
        @(negedge clk);
        chk("fill_busy", 64'(addr_data_bus_busy), 64'd1);
        chk("fill_ack", 64'(bus_respack), 64'd0);
        chk("fill_av", 64'(data_available), 64'd0);
        chk("ack_count", 64'(acks), 64'd8);
        step();
        do_vec(line, FLAG_READ, 1'b1, mw(line));
        chk("idle_busy", 64'(addr_data_bus_busy), 64'd0);
    endtask

    initial begin
        reset = 1'b0; addr = '0; rd_wr_evict_flag = FLAG_IDLE;
        bus_respcyc = 1'b0; bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0;
        addr_data_abtr_grant = 1'b0; store_data_abtr_grant = 1'b0;

        tbl[0] = '{a: 64'h203C, f: FLAG_READ, av: 1'b1, d: mw(64'h203C)};
        tbl[1] = '{a: 64'h3008, f: FLAG_READ, av: 1'b1, d: mw(64'h3008)};
        tbl[2] = '{a: 64'h3003, f: FLAG_READ, av: 1'b1, d: mw(64'h3000)};
        tbl[3] = '{a: 64'h2000, f: FLAG_IDLE, av: 1'b0, d: 32'h0};
        tbl[4] = '{a: 64'h2000, f: 2'd3,      av: 1'b0, d: 32'h0};
        tbl[5] = '{a: 64'h5000, f: FLAG_IDLE, av: 1'b0, d: 32'h0};
        tbl[6] = '{a: 64'h3034, f: FLAG_READ, av: 1'b1, d: mw(64'h3034)};
        tbl[7] = '{a: 64'h2018, f: FLAG_READ, av: 1'b1, d: mw(64'h2018)};

        #3;
        chk_all_zero("reset");
        step();
        reset = 1'b1;
        step();

        refill(64'h1000, 0, 0, 0, 1'b0, 1'b0, 64'h0, 32'h0, 0);
        do_vec(64'h1004, FLAG_READ, 1'b1, mw(64'h1004));
        refill(64'h2000, 0, 0, 0, 1'b0, 1'b0, 64'h0, 32'h0, 0);
        refill(64'h3000, 0, 0, 0, 1'b0, 1'b0, 64'h0, 32'h0, 0);

        for (int i = 0; i < 8; i++)
            do_vec(tbl[i].a, tbl[i].f, tbl[i].av, tbl[i].d);

        // 0x1000 was evicted by 0x3000; refill with slow arbiter/bus and a hit elsewhere mid-refill.
        refill(64'h1000, 5, 3, 2, 1'b0, 1'b1, 64'h3004, mw(64'h3004), 0);
        do_vec(64'h2000, FLAG_READ, 1'b1, mw(64'h2000));

        do_vec(64'h1000, FLAG_INVAL, 1'b0, 32'h0);
        do_vec(64'h2004, FLAG_READ, 1'b1, mw(64'h2004));
        refill(64'h1000, 1, 1, 0, 1'b1, 1'b0, 64'h0, 32'h0, 0);

        refill(64'h4000, 0, 0, 0, 1'b0, 1'b0, 64'h0, 32'h0, 3);
        addr = 64'h1000; rd_wr_evict_flag = FLAG_READ;
        @(negedge clk);
        chk("empty_after_reset", 64'(data_available), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/set_associative_cache.md
Name: set_associative_cache

Overview:
- Read-only, 2-way set-associative instruction cache between the fetch stage and the shared memory bus.
- Hits return a 32-bit word combinationally from the current address.
- Misses win the address/data bus arbiter, issue one line-read request and collect 8 response beats into the LRU way.
- Flag value 2 invalidates the addressed line.

Parameters:
ADDRESS_WIDTH, 64, byte address width
BUS_DATA_WIDTH, 64, bus beat width
BUS_TAG_WIDTH, 13, bus tag width
DATA_WIDTH, 32, read_data width
NUM_SETS, 64, sets (power of 2)
NUM_WAYS, 2, ways (fixed at 2)
LINE_BYTES, 64, line size; beats per line = LINE_BYTES*8/BUS_DATA_WIDTH = 8

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
rd_wr_evict_flag  in  2  0 idle, 1 read, 2 invalidate line, 3 reserved (= idle)
read_data  out  DATA_WIDTH  word at addr[5:2] of hit line; 0 when no hit
data_available  out  1  read hit on current addr this cycle
bus_reqcyc  out  1  bus request valid
bus_respack  out  1  acknowledge of current response beat
bus_req  out  BUS_DATA_WIDTH  line-aligned request address
bus_reqtag  out  BUS_TAG_WIDTH  request tag; READ_TAG = 13'h1100
bus_respcyc  in  1  response beat valid
bus_reqack  in  1  request accepted
bus_resp  in  BUS_DATA_WIDTH  response beat data
bus_resptag  in  BUS_TAG_WIDTH  response tag, not checked
addr_data_abtr_grant  in  1  address/data bus granted
addr_data_abtr_reqcyc  out  1  request address/data bus
store_data_abtr_grant  in  1  unused
store_data_abtr_reqcyc  out  1  constant 0
store_data_bus_busy  out  1  constant 0
addr_data_bus_busy  out  1  high while this cache owns the address/data bus

Behaviour:
- Address split: offset = addr[5:0], index = addr[11:6], tag = addr[63:12]; word select = addr[5:2].
- Beat packing: beat k holds line bytes 8k..8k+7, little-endian. Word w = beat w/2, bits [31:0] if w even, [63:32] if w odd.
- Per set: valid[2], tag[2], data[2], lru (1 bit, points to victim way).
- Reset (reset=0, async): all valid=0, lru=0, FSM=IDLE; every output 0.
- Hit, combinational: flag==1 and valid & tag match in a way -> data_available=1, read_data=word, same cycle, no latency.
- Hit update: on the clock edge of a hit, lru := other way.
- FSM states, all outputs registered or decoded from state:
  - IDLE: flag==1 and miss -> latch line address {addr[63:6],6'b0} and victim = lru[index]; go ARB.
  - ARB: addr_data_abtr_reqcyc=1; on grant go REQ.
  - REQ: bus_reqcyc=1, bus_req=latched address, bus_reqtag=READ_TAG, addr_data_bus_busy=1; hold until bus_reqack, then go RESP.
  - RESP: addr_data_bus_busy=1. Each cycle with bus_respcyc=1: store bus_resp into beat counter slot of the line buffer, bus_respack=1 that same cycle (combinational from bus_respcyc), counter+1. After beat 7 go FILL.
  - FILL: write buffer, latched tag and valid=1 into victim way; lru := other way; go IDLE.
- Hit served the cycle after FILL, if addr still maps to the filled line.
- addr changes during a refill: refill completes for the latched address. data_available reflects only the current addr, so a hit on another resident line is reported even during a refill.
- Flag==2 in IDLE: clear valid of the matching way (no writeback; lines never dirty). Ignored outside IDLE.
- Flag==0 or 3: data_available=0, no state change.
- Miss with flag dropped to 0 after ARB entry: refill still completes.
- Never more than one outstanding request.

Decomposition:
- Package set_associative_cache_pkg: READ_TAG, state enum {IDLE,ARB,REQ,RESP,FILL}, flag constants FLAG_IDLE/FLAG_READ/FLAG_INVAL.
- Sub-module cache_refill_fsm: arbiter/bus handshake, beat counter and line buffer. Top holds the arrays and lookup logic.

Test Plan:
- Reset then flag=1, addr=0x1000 -> data_available=0; arbiter req; grant -> bus_reqcyc, bus_req=0x1000, tag 0x1100. 8 beats of 0x(k)(k+1)... -> next cycle after FILL data_available=1, read_data = beat0[31:0].
- Sequential read 0x1004 after that fill -> same-cycle hit, read_data = beat0[63:32], no bus activity.
- Lines 0x1000, 0x2000, 0x3000 (same index) -> third fill evicts 0x1000 (LRU); re-reading 0x2000 hits, 0x1000 misses.
- Grant delayed 5 cycles and reqack delayed 3 -> bus_reqcyc held steady, addr_data_bus_busy high from REQ through FILL.
- Gaps between response beats -> bus_respack only with bus_respcyc, exactly 8 acks.
- Flag=2 on resident 0x1000 -> next read of 0x1000 misses. Reset asserted mid-RESP -> all outputs 0 immediately, cache empty.
